// File: rtl/mcu_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes,
// FSM state encoding and instruction field positions.
package mcu_pkg;

  localparam int OPC_W = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_INK  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcode sits directly above the DATA_W-bit operand field.
  function automatic int opc_lsb(input int data_w);
    return data_w;
  endfunction

  // Opcodes LD..MUL go through the data-memory handshake.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/mcu_core_p_if.sv
// Instruction-fetch and data-memory req/rdy buses of the core.
interface mcu_core_p_if #(
  parameter int DATA_W    = 8,
  parameter int IM_ADDR_W = 8,
  parameter int DM_ADDR_W = 8,
  parameter int INST_W    = DATA_W + 4
);
  logic [IM_ADDR_W-1:0] im_addr;
  logic                 im_req;
  logic                 im_rdy;
  logic [INST_W-1:0]    im_data;
  logic [DM_ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0]    dm_wdata;
  logic                 dm_we;
  logic                 dm_req;
  logic                 dm_rdy;
  logic [DATA_W-1:0]    dm_rdata;

  modport master (
    output im_addr, im_req, dm_addr, dm_wdata, dm_we, dm_req,
    input  im_rdy, im_data, dm_rdy, dm_rdata
  );

  modport slave (
    input  im_addr, im_req, dm_addr, dm_wdata, dm_we, dm_req,
    output im_rdy, im_data, dm_rdy, dm_rdata
  );
endinterface

// File: rtl/mcu_alu_p.sv
// Combinational arithmetic unit: add/subtract with carry (borrow) and
// zero, plus a full-width unsigned product.
module mcu_alu_p
  import mcu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   res,
  output logic                carry,
  output logic                zero,
  output logic [2*DATA_W-1:0] prod
);
  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Pick the add or subtract result; bit DATA_W is carry or borrow.
  always_comb begin
    res   = sum_s[DATA_W-1:0];
    carry = sum_s[DATA_W];
    case (op)
      OP_SUB: begin
        res   = diff_s[DATA_W-1:0];
        carry = diff_s[DATA_W];
      end
      default: begin
        res   = sum_s[DATA_W-1:0];
        carry = sum_s[DATA_W];
      end
    endcase
  end

  assign zero = (res == {DATA_W{1'b0}});
endmodule

// File: rtl/mcu_core_p.sv
// Multi-cycle accumulator core: FETCH -> EXEC [-> MEM] -> FETCH, with
// wait-state tolerant instruction and data handshakes. All bus outputs
// and result ports come straight from registers.
module mcu_core_p
  import mcu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IM_ADDR_W = 8,
  parameter int DM_ADDR_W = 8,
  parameter int INST_W    = DATA_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mcu_input,
  input  logic [DATA_W-1:0] KB,
  mcu_core_p_if.master      bus,
  output logic [DATA_W-1:0] Output_LSB,
  output logic [DATA_W-1:0] Output_MSB,
  output logic              halted
);
  localparam int                   OPC_LSB = opc_lsb(DATA_W);
  localparam logic [IM_ADDR_W-1:0] PC_ONE  = {{(IM_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]    ZERO_D  = {DATA_W{1'b0}};

  state_t               state_r, state_nxt;
  logic [IM_ADDR_W-1:0] pc_r, pc_nxt;
  logic [DATA_W-1:0]    acc_r, acc_nxt;
  logic [INST_W-1:0]    ir_r, ir_nxt;
  logic                 zero_r, zero_nxt;
  logic                 carry_r, carry_nxt;
  logic [DATA_W-1:0]    out_lsb_r, out_lsb_nxt;
  logic [DATA_W-1:0]    out_msb_r, out_msb_nxt;
  logic [DM_ADDR_W-1:0] dm_addr_r, dm_addr_nxt;
  logic [DATA_W-1:0]    dm_wdata_r, dm_wdata_nxt;
  logic                 dm_we_r, dm_we_nxt;
  logic                 im_req_r, dm_req_r, halted_r;

  logic [3:0]           opcode_s;
  logic [DATA_W-1:0]    imm_s;
  logic                 fetch_done_s, mem_done_s;
  logic [DATA_W-1:0]    alu_res_s;
  logic                 alu_carry_s, alu_zero_s;
  logic [2*DATA_W-1:0]  alu_prod_s;

  assign opcode_s = ir_r[OPC_LSB +: OPC_W];
  assign imm_s    = ir_r[DATA_W-1:0];

  // A handshake completes only while our own request is up.
  assign fetch_done_s = (state_r == ST_FETCH) && im_req_r && bus.im_rdy;
  assign mem_done_s   = (state_r == ST_MEM) && dm_req_r && bus.dm_rdy;

  mcu_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op    (opcode_s),
    .a     (acc_r),
    .b     (bus.dm_rdata),
    .res   (alu_res_s),
    .carry (alu_carry_s),
    .zero  (alu_zero_s),
    .prod  (alu_prod_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_FETCH: begin
        if (fetch_done_s) state_nxt = ST_EXEC;
        else              state_nxt = ST_FETCH;
      end
      ST_EXEC: begin
        if (opcode_s == OP_HALT)     state_nxt = ST_HALT;
        else if (is_mem_op(opcode_s)) state_nxt = ST_MEM;
        else                          state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_done_s) state_nxt = ST_FETCH;
        else            state_nxt = ST_MEM;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Next values of the architectural registers and bus outputs.
  always_comb begin
    pc_nxt       = pc_r;
    acc_nxt      = acc_r;
    ir_nxt       = ir_r;
    zero_nxt     = zero_r;
    carry_nxt    = carry_r;
    out_lsb_nxt  = out_lsb_r;
    out_msb_nxt  = out_msb_r;
    dm_addr_nxt  = dm_addr_r;
    dm_wdata_nxt = dm_wdata_r;
    dm_we_nxt    = dm_we_r;
    case (state_r)
      ST_FETCH: begin
        if (fetch_done_s) begin
          ir_nxt = bus.im_data;
          pc_nxt = pc_r + PC_ONE;
        end else begin
          ir_nxt = ir_r;
        end
      end
      ST_EXEC: begin
        case (opcode_s)
          OP_LDI: begin
            acc_nxt  = imm_s;
            zero_nxt = (imm_s == ZERO_D);
          end
          OP_IN: begin
            acc_nxt  = mcu_input;
            zero_nxt = (mcu_input == ZERO_D);
          end
          OP_INK: begin
            acc_nxt  = KB;
            zero_nxt = (KB == ZERO_D);
          end
          OP_JMP: pc_nxt = imm_s[IM_ADDR_W-1:0];
          OP_JZ: begin
            if (zero_r) pc_nxt = imm_s[IM_ADDR_W-1:0];
            else        pc_nxt = pc_r;
          end
          OP_OUT: begin
            out_lsb_nxt = acc_r;
            out_msb_nxt = ZERO_D;
          end
          OP_LD, OP_ST, OP_ADD, OP_SUB, OP_MUL: begin
            dm_addr_nxt  = imm_s[DM_ADDR_W-1:0];
            dm_we_nxt    = (opcode_s == OP_ST);
            dm_wdata_nxt = acc_r;
          end
          default: begin
            pc_nxt = pc_r;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_done_s) begin
          dm_we_nxt = 1'b0;
          case (opcode_s)
            OP_LD: begin
              acc_nxt  = bus.dm_rdata;
              zero_nxt = (bus.dm_rdata == ZERO_D);
            end
            OP_ADD, OP_SUB: begin
              acc_nxt   = alu_res_s;
              carry_nxt = alu_carry_s;
              zero_nxt  = alu_zero_s;
            end
            OP_MUL: {out_msb_nxt, out_lsb_nxt} = alu_prod_s;
            default: begin
              acc_nxt = acc_r;
            end
          endcase
        end else begin
          dm_we_nxt = dm_we_r;
        end
      end
      default: begin
        pc_nxt = pc_r;
      end
    endcase
  end

  // Datapath and output registers; requests follow the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= {IM_ADDR_W{1'b0}};
      acc_r      <= ZERO_D;
      ir_r       <= {INST_W{1'b0}};
      zero_r     <= 1'b1;
      carry_r    <= 1'b0;
      out_lsb_r  <= ZERO_D;
      out_msb_r  <= ZERO_D;
      dm_addr_r  <= {DM_ADDR_W{1'b0}};
      dm_wdata_r <= ZERO_D;
      dm_we_r    <= 1'b0;
      im_req_r   <= 1'b0;
      dm_req_r   <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      pc_r       <= pc_nxt;
      acc_r      <= acc_nxt;
      ir_r       <= ir_nxt;
      zero_r     <= zero_nxt;
      carry_r    <= carry_nxt;
      out_lsb_r  <= out_lsb_nxt;
      out_msb_r  <= out_msb_nxt;
      dm_addr_r  <= dm_addr_nxt;
      dm_wdata_r <= dm_wdata_nxt;
      dm_we_r    <= dm_we_nxt;
      im_req_r   <= (state_nxt == ST_FETCH);
      dm_req_r   <= (state_nxt == ST_MEM);
      halted_r   <= (state_nxt == ST_HALT);
    end
  end

  assign bus.im_addr  = pc_r;
  assign bus.im_req   = im_req_r;
  assign bus.dm_addr  = dm_addr_r;
  assign bus.dm_wdata = dm_wdata_r;
  assign bus.dm_we    = dm_we_r;
  assign bus.dm_req   = dm_req_r;
  assign Output_LSB   = out_lsb_r;
  assign Output_MSB   = out_msb_r;
  assign halted       = halted_r;
endmodule

// File: tb/tb_mcu_core_p.sv
// Directed bench for mcu_core_p: table of short programs plus hand-written
// sequences for reset, wait states, store, control flow and mid-access reset.
module tb_mcu_core_p;
  import mcu_pkg::*;

  typedef struct {
    logic [11:0] i0, i1, i2, i3;
    logic [7:0]  exp_lsb, exp_msb, exp_acc;
    logic        exp_c, exp_z;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mcu_input = 8'h3C;
  logic [7:0] kb = 8'hA5;
  logic [7:0] out_lsb, out_msb;
  logic       halted;
  logic [11:0] rom [256];
  logic [7:0]  dm  [256];
  logic [7:0]  st_addr = 8'h00;
  logic [7:0]  st_data = 8'h00;
  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;

  mcu_core_p_if bus ();

  mcu_core_p dut (
    .clk        (clk),
    .rst        (rst),
    .mcu_input  (mcu_input),
    .KB         (kb),
    .bus        (bus),
    .Output_LSB (out_lsb),
    .Output_MSB (out_msb),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign bus.im_data  = rom[bus.im_addr];
  assign bus.dm_rdata = dm[bus.dm_addr];

  // Capture completed stores.
  always @(posedge clk) begin
    if (rst && bus.dm_req && bus.dm_rdy && bus.dm_we) begin
      st_addr <= bus.dm_addr;
      st_data <= bus.dm_wdata;
    end
  end

  // Count cycles where both requests are up.
  always @(negedge clk) begin
    if (bus.im_req && bus.dm_req) overlap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  vec_t tv [9];
  logic [7:0] seen [$];
  logic [7:0] exp_pc [5];
  int req_cnt;

  initial begin
    for (int i = 0; i < 256; i++) dm[i] = 8'h00;
    dm[8'h10] = 8'hF0; dm[8'h11] = 8'hFF; dm[8'h13] = 8'h80;
    dm[8'h14] = 8'h00; dm[8'h15] = 8'h05; dm[8'h16] = 8'h20;
    bus.im_rdy = 1'b1;
    bus.dm_rdy = 1'b1;

    //        i0       i1       i2       i3       lsb    msb    acc    c     z
    tv[0] = '{12'h105, 12'hB00, 12'h000, 12'h000, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0};
    tv[1] = '{12'h120, 12'h410, 12'h510, 12'hB00, 8'h20, 8'h00, 8'h20, 1'b1, 1'b0};
    tv[2] = '{12'h1FF, 12'h611, 12'h000, 12'h000, 8'h01, 8'hFE, 8'hFF, 1'b0, 1'b0};
    tv[3] = '{12'h180, 12'h413, 12'hB00, 12'h000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    tv[4] = '{12'h700, 12'hB00, 12'h800, 12'h000, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0};
    tv[5] = '{12'h107, 12'h214, 12'hB00, 12'h000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tv[6] = '{12'h103, 12'h515, 12'hB00, 12'h000, 8'hFE, 8'h00, 8'hFE, 1'b1, 1'b0};
    tv[7] = '{12'h109, 12'hC00, 12'hB00, 12'h000, 8'h09, 8'h00, 8'h09, 1'b0, 1'b0};
    tv[8] = '{12'h110, 12'h616, 12'h414, 12'h000, 8'h00, 8'h02, 8'h10, 1'b0, 1'b0};

    // Reset state and basic fetch timing.
    clear_rom();
    rom[0] = 12'h105; rom[1] = 12'hB00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst im_req", 16'(bus.im_req), 16'h0);
    check("rst dm_req", 16'(bus.dm_req), 16'h0);
    check("rst halted", 16'(halted), 16'h0);
    check("rst out_lsb", 16'(out_lsb), 16'h00);
    check("rst acc", 16'(dut.acc_r), 16'h00);
    check("rst zero", 16'(dut.zero_r), 16'h1);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("c0 im_req", 16'(bus.im_req), 16'h1);
    check("c0 im_addr", 16'(bus.im_addr), 16'h00);
    step();
    check("c1 im_req", 16'(bus.im_req), 16'h0);
    step();
    check("c2 im_addr", 16'(bus.im_addr), 16'h01);
    step();
    step();
    check("c4 out_lsb", 16'(out_lsb), 16'h05);
    check("c4 out_msb", 16'(out_msb), 16'h00);
    check("c4 im_addr", 16'(bus.im_addr), 16'h02);

    // Fetch wait states.
    bus.im_rdy = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wait%0d im_req", k), 16'(bus.im_req), 16'h1);
      check($sformatf("wait%0d im_addr", k), 16'(bus.im_addr), 16'h00);
      if (k == 3) bus.im_rdy = 1'b1;
      step();
    end
    check("wait c4 acc", 16'(dut.acc_r), 16'h00);
    step();
    check("wait c5 acc", 16'(dut.acc_r), 16'h05);

    // Table of short programs ending in HALT.
    for (int v = 0; v < 9; v++) begin
      clear_rom();
      rom[0] = tv[v].i0; rom[1] = tv[v].i1; rom[2] = tv[v].i2; rom[3] = tv[v].i3;
      do_reset();
      for (int c = 0; c < 60 && !halted; c++) step();
      check($sformatf("v%0d halted", v), 16'(halted), 16'h1);
      check($sformatf("v%0d out_lsb", v), 16'(out_lsb), 16'(tv[v].exp_lsb));
      check($sformatf("v%0d out_msb", v), 16'(out_msb), 16'(tv[v].exp_msb));
      check($sformatf("v%0d acc", v), 16'(dut.acc_r), 16'(tv[v].exp_acc));
      check($sformatf("v%0d carry", v), 16'(dut.carry_r), 16'(tv[v].exp_c));
      check($sformatf("v%0d zero", v), 16'(dut.zero_r), 16'(tv[v].exp_z));
    end

    // Store with data wait states.
    clear_rom();
    rom[0] = 12'h1FF; rom[1] = 12'h312;
    bus.dm_rdy = 1'b0;
    do_reset();
    for (int c = 0; c < 20 && !bus.dm_req; c++) step();
    check("st dm_req", 16'(bus.dm_req), 16'h1);
    check("st dm_we", 16'(bus.dm_we), 16'h1);
    check("st dm_wdata", 16'(bus.dm_wdata), 16'hFF);
    check("st dm_addr", 16'(bus.dm_addr), 16'h12);
    step();
    step();
    check("st hold req", 16'(bus.dm_req), 16'h1);
    check("st hold we", 16'(bus.dm_we), 16'h1);
    check("st hold addr", 16'(bus.dm_addr), 16'h12);
    check("st no im_req", 16'(bus.im_req), 16'h0);
    bus.dm_rdy = 1'b1;
    step();
    check("st done req", 16'(bus.dm_req), 16'h0);
    check("st done we", 16'(bus.dm_we), 16'h0);
    check("st written addr", 16'(st_addr), 16'h12);
    check("st written data", 16'(st_data), 16'hFF);

    // Taken JZ, JMP to top of memory, pc wrap.
    clear_rom();
    rom[0] = 12'h100; rom[1] = 12'hA40; rom[8'h40] = 12'h9FF; rom[8'hFF] = 12'h000;
    exp_pc = '{8'h00, 8'h01, 8'h40, 8'hFF, 8'h00};
    seen.delete();
    do_reset();
    for (int c = 0; c < 40 && seen.size() < 5; c++) begin
      if (bus.im_req && bus.im_rdy) seen.push_back(bus.im_addr);
      step();
    end
    check("flow fetch count", 16'(seen.size()), 16'd5);
    for (int i = 0; i < seen.size(); i++)
      check($sformatf("flow fetch%0d", i), 16'(seen[i]), 16'(exp_pc[i]));

    // Untaken JZ then HALT: core stays quiet.
    clear_rom();
    rom[0] = 12'h101; rom[1] = 12'hA40; rom[2] = 12'hF00; rom[8'h40] = 12'h000;
    do_reset();
    for (int c = 0; c < 30 && !halted; c++) step();
    check("halt halted", 16'(halted), 16'h1);
    check("halt pc", 16'(bus.im_addr), 16'h03);
    req_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.im_req || bus.dm_req) req_cnt++;
    end
    check("halt no req", 16'(req_cnt), 16'd0);
    check("halt sticky", 16'(halted), 16'h1);

    // Reset during a stalled data read.
    clear_rom();
    rom[0] = 12'h133; rom[1] = 12'h210;
    bus.dm_rdy = 1'b0;
    do_reset();
    for (int c = 0; c < 20 && !bus.dm_req; c++) step();
    check("mrst dm_req", 16'(bus.dm_req), 16'h1);
    step();
    check("mrst stall", 16'(bus.dm_req), 16'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mrst drop", 16'(bus.dm_req), 16'h0);
    check("mrst acc", 16'(dut.acc_r), 16'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.dm_rdy = 1'b1;
    step();
    check("mrst refetch req", 16'(bus.im_req), 16'h1);
    check("mrst refetch addr", 16'(bus.im_addr), 16'h00);
    check("mrst dm_req idle", 16'(bus.dm_req), 16'h0);

    check("req overlap", 16'(overlap_cnt), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
